can_clic_pend: RTL and testbench

- Per-interrupt capture stage directly upstream of the can_clic arbiter.
- Synchronises raw interrupt lines and detects level or edge triggers.
- Holds per-source pending (ip), enable (ie), trigger mode and priority state behind a simple register port.
- Presents the packed entries vector that can_clic consumes; clears pending on core claim.

---
 rtl/can_clic_pend.sv | 97 +++++++++
 tb/tb_can_clic_pend.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/can_clic_pend.sv
// rtl/can_clic_pend.sv - per-source interrupt capture and pending state for can_clic
// Synchronises raw irq lines, detects level/edge triggers and exposes {prio, ip & ie} entries.
module can_clic_pend #(
  parameter int N_IRQ  = 2,
  parameter int PRIO_W = 2,
  parameter int IDX_W  = $clog2(N_IRQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_IRQ-1:0]           irq_i,
  input  logic                       reg_we,
  input  logic [IDX_W-1:0]           reg_addr,
  input  logic [2+PRIO_W:0]          reg_wdata,
  output logic [2+PRIO_W:0]          reg_rdata,
  input  logic                       claim_valid,
  input  logic [IDX_W-1:0]           claim_index,
  output logic [N_IRQ-1:0][PRIO_W:0] entries
);

  logic [N_IRQ-1:0] s1_q, s1_d;
  logic [N_IRQ-1:0] s2_q, s2_d;
  logic [N_IRQ-1:0] prev_q, prev_d;
  logic [N_IRQ-1:0] ip_q, ip_d;
  logic [N_IRQ-1:0] ie_q, ie_d;
  logic [N_IRQ-1:0] trig_q, trig_d;
  logic [N_IRQ-1:0][PRIO_W-1:0] prio_q, prio_d;

  always_comb begin
    logic wr_hit;
    logic clm_hit;
    s1_d   = irq_i;
    s2_d   = s1_q;
    prev_d = s2_q;
    ip_d   = ip_q;
    ie_d   = ie_q;
    trig_d = trig_q;
    prio_d = prio_q;
    wr_hit  = 1'b0;
    clm_hit = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      // Out-of-range addresses never equal any in-range index, so they fall through as no-ops.
      wr_hit  = reg_we && (reg_addr == IDX_W'(i));
      clm_hit = claim_valid && (claim_index == IDX_W'(i));
      if (!trig_q[i]) begin
        ip_d[i] = s2_q[i];
      end else if (wr_hit) begin
        ip_d[i] = reg_wdata[0];
      end else if (s2_q[i] && !prev_q[i]) begin
        ip_d[i] = 1'b1;
      end else if (clm_hit) begin
        ip_d[i] = 1'b0;
      end
      if (wr_hit) begin
        ie_d[i]   = reg_wdata[1];
        trig_d[i] = reg_wdata[2];
        prio_d[i] = reg_wdata[3 +: PRIO_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      ip_q   <= '0;
      ie_q   <= '0;
      trig_q <= '0;
      prio_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      ip_q   <= ip_d;
      ie_q   <= ie_d;
      trig_q <= trig_d;
      prio_q <= prio_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (reg_addr == IDX_W'(i)) begin
        reg_rdata = {prio_q[i], trig_q[i], ie_q[i], ip_q[i]};
      end
    end
  end

  always_comb begin
    entries = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      entries[i] = {prio_q[i], ip_q[i] & ie_q[i]};
    end
  end

endmodule

// File: tb/tb_can_clic_pend.sv
// tb/tb_can_clic_pend.sv - self-checking bench for can_clic_pend
module tb_can_clic_pend;

  typedef logic [1:0][2:0] ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] irq_i = '0;
  logic       reg_we = 1'b0;
  logic [1:0] reg_addr = '0;
  logic [4:0] reg_wdata = '0;
  logic [4:0] reg_rdata;
  logic       claim_valid = 1'b0;
  logic [1:0] claim_index = '0;
  ent_t       entries;

  int n_pass = 0;
  int n_total = 0;

  logic [1:0] m_ip, m_ie, m_edg;
  logic [1:0] m_prio [2];
  logic [1:0] hist [$];

  can_clic_pend #(.N_IRQ(2), .PRIO_W(2), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .claim_valid(claim_valid),
    .claim_index(claim_index), .entries(entries)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_ip = '0; m_ie = '0; m_edg = '0;
    m_prio[0] = '0; m_prio[1] = '0;
    hist.delete();
  endtask

  function automatic ent_t exp_entries();
    ent_t r;
    for (int i = 0; i < 2; i++) r[i] = {m_prio[i], m_ip[i] & m_ie[i]};
    return r;
  endfunction

  function automatic logic [4:0] exp_rdata(input logic [1:0] a);
    if (a > 2'd1) return 5'd0;
    return {m_prio[a[0]], m_edg[a[0]], m_ie[a[0]], m_ip[a[0]]};
  endfunction

  // One rising edge; the model sees the samples two and three edges back as sync and prev.
  task automatic tick();
    logic [1:0] cur, s2, prv, nip;
    bit wr, clm;
    cur = irq_i;
    if (reset) begin
      @(posedge clk); #1;
      model_clear();
      return;
    end
    s2  = (hist.size() > 1) ? hist[1] : 2'b00;
    prv = (hist.size() > 2) ? hist[2] : 2'b00;
    nip = m_ip;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      wr  = reg_we && (reg_addr == 2'(i));
      clm = claim_valid && (claim_index == 2'(i));
      if (!m_edg[i]) nip[i] = s2[i];
      else if (wr) nip[i] = reg_wdata[0];
      else if (s2[i] && !prv[i]) nip[i] = 1'b1;
      else if (clm) nip[i] = 1'b0;
      if (wr) begin
        m_ie[i] = reg_wdata[1];
        m_edg[i] = reg_wdata[2];
        m_prio[i] = reg_wdata[4:3];
      end
    end
    m_ip = nip;
    hist.push_front(cur);
    if (hist.size() > 3) void'(hist.pop_back());
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    n_total++;
    if (entries !== 6'b000_000) $display("FAIL reset_entries got %b want %b", entries, 6'b0);
    else n_pass++;
    for (int a = 0; a < 2; a++) begin
      reg_addr = 2'(a);
      #1;
      n_total++;
      if (reg_rdata !== 5'd0) $display("FAIL reset_rdata%0d got %b want 00000", a, reg_rdata);
      else n_pass++;
    end
  endtask

  task automatic test_edge_capture();
    reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 5'b10_1_1_0;
    tick();
    reg_we = 1'b0;
    tick();
    irq_i[0] = 1'b1;
    tick();
    irq_i[0] = 1'b0;
    tick();
    n_total++;
    if (entries[0] !== 3'b100) $display("FAIL edge_early got %b want 100", entries[0]);
    else n_pass++;
    tick();
    n_total++;
    if (entries[0] !== 3'b101) $display("FAIL edge_set got %b want 101", entries[0]);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (entries[0] !== 3'b101) $display("FAIL edge_hold got %b want 101", entries[0]);
    else n_pass++;
    claim_valid = 1'b1; claim_index = 2'd0;
    tick();
    claim_valid = 1'b0;
    n_total++;
    if (entries[0] !== 3'b100) $display("FAIL edge_claim got %b want 100", entries[0]);
    else n_pass++;
    irq_i[0] = 1'b1;
    tick();
    irq_i[0] = 1'b0;
    tick();
    claim_valid = 1'b1; claim_index = 2'd0;
    tick();
    claim_valid = 1'b0;
    n_total++;
    if (entries[0] !== 3'b101) $display("FAIL rise_beats_claim got %b want 101", entries[0]);
    else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_level();
    reg_we = 1'b1; reg_addr = 2'd1; reg_wdata = 5'b01_0_1_0;
    tick();
    reg_we = 1'b0;
    irq_i[1] = 1'b1;
    repeat (2) tick();
    n_total++;
    if (entries[1] !== 3'b010) $display("FAIL level_early got %b want 010", entries[1]);
    else n_pass++;
    tick();
    n_total++;
    if (entries[1] !== 3'b011) $display("FAIL level_set got %b want 011", entries[1]);
    else n_pass++;
    claim_valid = 1'b1; claim_index = 2'd1;
    tick();
    claim_valid = 1'b0;
    n_total++;
    if (entries[1] !== 3'b011) $display("FAIL level_claim got %b want 011", entries[1]);
    else n_pass++;
    irq_i[1] = 1'b0;
    repeat (2) tick();
    n_total++;
    if (entries[1] !== 3'b011) $display("FAIL level_drop_early got %b want 011", entries[1]);
    else n_pass++;
    tick();
    n_total++;
    if (entries[1] !== 3'b010) $display("FAIL level_drop got %b want 010", entries[1]);
    else n_pass++;
  endtask

  task automatic test_ie_mask();
    reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 5'b10_1_0_1;
    tick();
    reg_we = 1'b0;
    n_total++;
    if (entries[0] !== 3'b100) $display("FAIL ie_off got %b want 100", entries[0]);
    else n_pass++;
    n_total++;
    if (reg_rdata !== 5'b10101) $display("FAIL ie_off_rdata got %b want 10101", reg_rdata);
    else n_pass++;
    reg_we = 1'b1; reg_wdata = 5'b10_1_1_1;
    tick();
    reg_we = 1'b0;
    n_total++;
    if (entries[0] !== 3'b101) $display("FAIL ie_on got %b want 101", entries[0]);
    else n_pass++;
    reg_we = 1'b1; reg_addr = 2'd2; reg_wdata = 5'b11111;
    tick();
    reg_we = 1'b0;
    #1;
    n_total++;
    if (reg_rdata !== 5'd0) $display("FAIL oor_rdata got %b want 00000", reg_rdata);
    else n_pass++;
    n_total++;
    if (entries !== 6'b010_101) $display("FAIL oor_entries got %b want 010101", entries);
    else n_pass++;
    reg_addr = 2'd1;
    #1;
    n_total++;
    if (reg_rdata !== 5'b01010) $display("FAIL oor_rdata1 got %b want 01010", reg_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    irq_i[0] = 1'b1;
    reset = 1'b1;
    model_clear();
    #1;
    n_total++;
    if (entries !== 6'b0) $display("FAIL reset_mid got %b want 000000", entries);
    else n_pass++;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    n_total++;
    if (entries !== 6'b0) $display("FAIL post_reset_entries got %b want 000000", entries);
    else n_pass++;
    reg_addr = 2'd0;
    #1;
    n_total++;
    if (reg_rdata !== 5'b00001) $display("FAIL post_reset_rdata got %b want 00001", reg_rdata);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      irq_i       = 2'($urandom_range(0, 3));
      reg_we      = ($urandom_range(0, 3) == 0);
      reg_addr    = 2'($urandom_range(0, 3));
      reg_wdata   = 5'($urandom_range(0, 31));
      claim_valid = ($urandom_range(0, 2) == 0);
      claim_index = 2'($urandom_range(0, 3));
      #1;
      n_total++;
      if (reg_rdata !== exp_rdata(reg_addr))
        $display("FAIL rand_rdata cyc %0d addr %0d got %b want %b", c, reg_addr, reg_rdata, exp_rdata(reg_addr));
      else n_pass++;
      tick();
      n_total++;
      if (entries !== exp_entries())
        $display("FAIL rand_entries cyc %0d got %b want %b", c, entries, exp_entries());
      else n_pass++;
    end
    reg_we = 1'b0;
    claim_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_capture();
    test_level();
    test_ie_mask();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
